// File: rtl/div_reservation_station.sv
// Divider reservation station: holds dispatched divide ops until both operands arrive, then issues the oldest ready op.
// Optional combinational dispatch bypass is enabled by defining DIV_RS_BYPASS_EN.
module div_reservation_station #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int RSsize     = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  dispatchValid_i,
    input  logic [63:0]           dispatchVal1_i,
    input  logic                  dispatchVal1Ready_i,
    input  logic [ROBsizeLog-1:0] dispatchVal1Tag_i,
    input  logic [63:0]           dispatchVal2_i,
    input  logic                  dispatchVal2Ready_i,
    input  logic [ROBsizeLog-1:0] dispatchVal2Tag_i,
    input  logic [9:0]            dispatchCommands_i,
    input  logic [ROBsizeLog-1:0] dispatchTag_i,
    output logic                  full_o,
    input  logic                  cdbValid_i,
    input  logic [ROBsizeLog-1:0] cdbTag_i,
    input  logic [63:0]           cdbVal_i,
    output logic [63:0]           reservationStationVal1_o,
    output logic [63:0]           reservationStationVal2_o,
    output logic [9:0]            reservationStationCommands_o,
    output logic [ROBsizeLog-1:0] reservationStationTag_o,
    output logic                  readyRS_o,
    input  logic                  stallRS_i
);
    localparam int IW = $clog2(RSsize);

    logic [RSsize-1:0]     valid_reg;
    logic [RSsize-1:0]     v1_rdy_reg;
    logic [RSsize-1:0]     v2_rdy_reg;
    logic [IW-1:0]         age_reg [RSsize];
    logic [63:0]           v1_reg  [RSsize];
    logic [63:0]           v2_reg  [RSsize];
    logic [ROBsizeLog-1:0] t1_reg  [RSsize];
    logic [ROBsizeLog-1:0] t2_reg  [RSsize];
    logic [9:0]            cmd_reg [RSsize];
    logic [ROBsizeLog-1:0] tag_reg [RSsize];

    logic [RSsize-1:0] entry_ready;
    logic              any_ready;
    logic [IW-1:0]     sel_idx;
    logic [IW-1:0]     sel_age;
    logic              free_found;
    logic [IW-1:0]     alloc_idx;
    logic              disp_v1_rdy;
    logic              disp_v2_rdy;
    logic [63:0]       disp_v1;
    logic [63:0]       disp_v2;
    logic              bypass;
    logic              issue;
    logic              dispatch_write;

    assign full_o = &valid_reg;

    // Operands may be satisfied by a CDB broadcast in the dispatch cycle itself.
    assign disp_v1_rdy = dispatchVal1Ready_i | (cdbValid_i & (cdbTag_i == dispatchVal1Tag_i));
    assign disp_v2_rdy = dispatchVal2Ready_i | (cdbValid_i & (cdbTag_i == dispatchVal2Tag_i));
    assign disp_v1     = dispatchVal1Ready_i ? dispatchVal1_i : cdbVal_i;
    assign disp_v2     = dispatchVal2Ready_i ? dispatchVal2_i : cdbVal_i;

    assign entry_ready = valid_reg & v1_rdy_reg & v2_rdy_reg;

    // Oldest ready entry wins; ages are unique among valid entries.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RSsize; i++) begin
            if (entry_ready[i] && (!any_ready || age_reg[i] > sel_age)) begin
                any_ready = 1'b1;
                sel_idx   = IW'(i);
                sel_age   = age_reg[i];
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        alloc_idx  = '0;
        for (int i = RSsize - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_found = 1'b1;
                alloc_idx  = IW'(i);
            end
        end
    end

`ifdef DIV_RS_BYPASS_EN
    assign bypass = ~any_ready & dispatchValid_i & ~full_o & ~flush_i & disp_v1_rdy & disp_v2_rdy;
`else
    assign bypass = 1'b0;
`endif

    assign readyRS_o      = any_ready | bypass;
    assign issue          = any_ready & ~stallRS_i;
    assign dispatch_write = dispatchValid_i & free_found & ~flush_i & ~(bypass & ~stallRS_i);

    always_comb begin
        reservationStationVal1_o     = '0;
        reservationStationVal2_o     = '0;
        reservationStationCommands_o = '0;
        reservationStationTag_o      = '0;
        if (any_ready) begin
            reservationStationVal1_o     = v1_reg[sel_idx];
            reservationStationVal2_o     = v2_reg[sel_idx];
            reservationStationCommands_o = cmd_reg[sel_idx];
            reservationStationTag_o      = tag_reg[sel_idx];
        end else if (bypass) begin
            reservationStationVal1_o     = disp_v1;
            reservationStationVal2_o     = disp_v2;
            reservationStationCommands_o = dispatchCommands_i;
            reservationStationTag_o      = dispatchTag_i;
        end
    end

    generate
        for (genvar gi = 0; gi < RSsize; gi++) begin : g_entry
            logic          wake1;
            logic          wake2;
            logic          is_alloc;
            logic          is_issued;
            logic [IW-1:0] age_next;

            assign wake1     = cdbValid_i & ~v1_rdy_reg[gi] & (t1_reg[gi] == cdbTag_i);
            assign wake2     = cdbValid_i & ~v2_rdy_reg[gi] & (t2_reg[gi] == cdbTag_i);
            assign is_alloc  = dispatch_write & (alloc_idx == IW'(gi));
            assign is_issued = issue & (sel_idx == IW'(gi));
            // Age is the rank among valid entries: older survivors close the gap left by an issue.
            assign age_next  = age_reg[gi]
                             - IW'(issue && (age_reg[gi] > sel_age))
                             + IW'(dispatch_write);

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    valid_reg[gi]  <= 1'b0;
                    v1_rdy_reg[gi] <= 1'b0;
                    v2_rdy_reg[gi] <= 1'b0;
                    age_reg[gi]    <= '0;
                end else if (flush_i) begin
                    valid_reg[gi]  <= 1'b0;
                end else if (is_alloc) begin
                    valid_reg[gi]  <= 1'b1;
                    v1_rdy_reg[gi] <= disp_v1_rdy;
                    v2_rdy_reg[gi] <= disp_v2_rdy;
                    age_reg[gi]    <= '0;
                end else if (valid_reg[gi]) begin
                    if (is_issued) begin
                        valid_reg[gi] <= 1'b0;
                    end else begin
                        if (wake1) v1_rdy_reg[gi] <= 1'b1;
                        if (wake2) v2_rdy_reg[gi] <= 1'b1;
                        age_reg[gi] <= age_next;
                    end
                end
            end

            // Payload carries no reset; it is only observed through valid entries.
            always_ff @(posedge clk_i) begin
                if (is_alloc) begin
                    v1_reg[gi]  <= disp_v1;
                    v2_reg[gi]  <= disp_v2;
                    t1_reg[gi]  <= dispatchVal1Tag_i;
                    t2_reg[gi]  <= dispatchVal2Tag_i;
                    cmd_reg[gi] <= dispatchCommands_i;
                    tag_reg[gi] <= dispatchTag_i;
                end else if (valid_reg[gi]) begin
                    if (wake1) v1_reg[gi] <= cdbVal_i;
                    if (wake2) v2_reg[gi] <= cdbVal_i;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_div_reservation_station.sv
// Scoreboard bench for div_reservation_station: queue-based reference model predicts issue order,
// a separate monitor checks every transfer against it.
module tb_div_reservation_station;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          d_valid;
    logic [63:0]   d_v1;
    logic          d_r1;
    logic [TW-1:0] d_t1;
    logic [63:0]   d_v2;
    logic          d_r2;
    logic [TW-1:0] d_t2;
    logic [9:0]    d_cmd;
    logic [TW-1:0] d_tag;
    logic          full;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [63:0]   cdb_val;
    logic [63:0]   rs_v1;
    logic [63:0]   rs_v2;
    logic [9:0]    rs_cmd;
    logic [TW-1:0] rs_tag;
    logic          ready_rs;
    logic          stall;

    always #5 clk = ~clk;

    div_reservation_station dut (
        .clk_i                        (clk),
        .reset_i                      (rst),
        .flush_i                      (flush),
        .dispatchValid_i              (d_valid),
        .dispatchVal1_i               (d_v1),
        .dispatchVal1Ready_i          (d_r1),
        .dispatchVal1Tag_i            (d_t1),
        .dispatchVal2_i               (d_v2),
        .dispatchVal2Ready_i          (d_r2),
        .dispatchVal2Tag_i            (d_t2),
        .dispatchCommands_i           (d_cmd),
        .dispatchTag_i                (d_tag),
        .full_o                       (full),
        .cdbValid_i                   (cdb_valid),
        .cdbTag_i                     (cdb_tag),
        .cdbVal_i                     (cdb_val),
        .reservationStationVal1_o     (rs_v1),
        .reservationStationVal2_o     (rs_v2),
        .reservationStationCommands_o (rs_cmd),
        .reservationStationTag_o      (rs_tag),
        .readyRS_o                    (ready_rs),
        .stallRS_i                    (stall)
    );

    typedef struct {
        logic          r1;
        logic [63:0]   v1;
        logic [TW-1:0] t1;
        logic          r2;
        logic [63:0]   v2;
        logic [TW-1:0] t2;
        logic [9:0]    cmd;
        logic [TW-1:0] tag;
    } op_t;

    op_t model_q[$];   // pending ops, oldest dispatch first
    op_t exp_q[$];     // ops the model says were transferred, in order
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check presentation/occupancy, then advance the model across the edge.
    task automatic step(input logic dv, input logic [63:0] a, input logic ar, input logic [TW-1:0] at,
                        input logic [63:0] b, input logic br, input logic [TW-1:0] bt,
                        input logic [9:0] cmd, input logic [TW-1:0] tg,
                        input logic cv, input logic [TW-1:0] ct, input logic [63:0] cval,
                        input logic st, input logic fl);
        int   sel;
        logic exp_full;
        logic acc;
        op_t  n;
        @(negedge clk);
        d_valid = dv; d_v1 = a; d_r1 = ar; d_t1 = at; d_v2 = b; d_r2 = br; d_t2 = bt;
        d_cmd = cmd; d_tag = tg; cdb_valid = cv; cdb_tag = ct; cdb_val = cval;
        stall = st; flush = fl;
        sel = -1;
        foreach (model_q[i]) if (sel < 0 && model_q[i].r1 && model_q[i].r2) sel = i;
        exp_full = (model_q.size() == 4);
        acc = dv && !exp_full && !fl;
        #1;
        check("readyRS", 64'(ready_rs), 64'(sel >= 0));
        check("full", 64'(full), 64'(exp_full));
        if (sel < 0) check("idle_val1", rs_v1, 64'd0);
        if (sel >= 0 && !st) begin
            exp_q.push_back(model_q[sel]);
            model_q.delete(sel);
        end
        if (fl) begin
            model_q.delete();
        end else begin
            foreach (model_q[i]) begin
                if (cv && !model_q[i].r1 && model_q[i].t1 == ct) begin
                    model_q[i].r1 = 1'b1; model_q[i].v1 = cval;
                end
                if (cv && !model_q[i].r2 && model_q[i].t2 == ct) begin
                    model_q[i].r2 = 1'b1; model_q[i].v2 = cval;
                end
            end
            if (acc) begin
                n.r1 = ar || (cv && ct == at); n.v1 = ar ? a : cval; n.t1 = at;
                n.r2 = br || (cv && ct == bt); n.v2 = br ? b : cval; n.t2 = bt;
                n.cmd = cmd; n.tag = tg;
                model_q.push_back(n);
            end
        end
    endtask

    task automatic idle(input logic st);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, 0);
    endtask

    task automatic put_ready(input logic [63:0] a, input logic [63:0] b, input logic [9:0] cmd,
                             input logic [TW-1:0] tg, input logic st);
        step(1, a, 1, 0, b, 1, 0, cmd, tg, 0, 0, 0, st, 0);
    endtask

    // Monitor: every transfer must match the next op the model expects.
    initial begin
        op_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ready_rs && !stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got tag %0d required none at %0t", rs_tag, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_val1", rs_v1, e.v1);
                    check("issue_val2", rs_v2, e.v2);
                    check("issue_cmd", 64'(rs_cmd), 64'(e.cmd));
                    check("issue_tag", 64'(rs_tag), 64'(e.tag));
                    $display("issue tag=%0d cmd=%0h val1=%0h val2=%0h", rs_tag, rs_cmd, rs_v1, rs_v2);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; flush = 0; d_valid = 0; d_v1 = 0; d_r1 = 0; d_t1 = 0; d_v2 = 0; d_r2 = 0;
        d_t2 = 0; d_cmd = 0; d_tag = 0; cdb_valid = 0; cdb_tag = 0; cdb_val = 0; stall = 0;
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(ready_rs), 64'd0);
        check("reset_full", 64'(full), 64'd0);
        check("reset_val1", rs_v1, 64'd0);
        check("reset_val2", rs_v2, 64'd0);
        check("reset_cmd", 64'(rs_cmd), 64'd0);
        check("reset_tag", 64'(rs_tag), 64'd0);
        rst = 1'b0;

        // Basic ready dispatch: presented one cycle later, gone the cycle after.
        put_ready(15, 3, 10, 3, 0);
        idle(0); idle(0);

        // Operand 2 wakes from the CDB two cycles after dispatch.
        step(1, 20, 1, 0, 0, 0, 5, 10'h1, 7, 0, 0, 0, 0, 0);
        idle(0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 4, 0, 0);
        idle(0); idle(0);

        // Fill under stall, overflow dispatch ignored, then drain in order.
        for (int i = 1; i <= 4; i++) put_ready(64'(100 + i), 64'(i), 10'(i), TW'(i), 1);
        put_ready(999, 9, 10'h3ff, 9, 1);
        repeat (6) idle(0);

        // Same-cycle CDB capture on dispatch.
        step(1, 0, 0, 6, 2, 1, 0, 10'h2, 11, 1, 6, 9, 0, 0);
        idle(0); idle(0);

        // Flush with three waiting ops, then a normal dispatch.
        for (int i = 0; i < 3; i++) step(1, 0, 0, TW'(20 + i), 0, 0, TW'(20 + i), 10'(i), TW'(12 + i), 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        put_ready(77, 7, 10'h7, 15, 0);
        idle(0); idle(0);

        // Asynchronous reset in the middle of a cycle with a full station.
        for (int i = 1; i <= 4; i++) put_ready(64'(200 + i), 64'(i), 10'(i), TW'(16 + i), 1);
        @(negedge clk);
        d_valid = 0; cdb_valid = 0; stall = 1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_full", 64'(full), 64'd0);
        check("async_reset_ready", 64'(ready_rs), 64'd0);
        model_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with small tag space so wakeups collide often.
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 1), TW'($urandom_range(0, 7)),
                 {$urandom, $urandom}, $urandom_range(0, 1), TW'($urandom_range(0, 7)),
                 10'($urandom), TW'($urandom_range(0, 31)),
                 $urandom_range(0, 1), TW'($urandom_range(0, 7)), {$urandom, $urandom},
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
        end

        guard = 0;
        while (model_q.size() != 0 && guard < 300) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 1), TW'($urandom_range(0, 7)), {$urandom, $urandom}, 0, 0);
            guard++;
        end
        check("drain_model_empty", 64'(model_q.size()), 64'd0);
        idle(0); idle(0);
        check("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_reservation_station.md
Name: div_reservation_station

Overview:
Reservation station feeding the divider issue/execute stage. It accepts dispatched divide ops from rename/dispatch and holds them until both operands are available. It captures operands broadcast on the common data bus (CDB). It presents one ready op at a time on the RS-side handshake of the divider stage, and sits directly upstream of that stage.

Parameters:
ROBsize, 32, number of ROB entries.
ROBsizeLog, $clog2(ROBsize+1), width of ROB tags.
RSsize, 4, number of station entries (2..8).

Ports:
clk_i  in  1  clock; all state updates on posedge.
reset_i  in  1  asynchronous, active-high reset.
flush_i  in  1  synchronous flush; invalidates all entries.
dispatchValid_i  in  1  dispatch request this cycle.
dispatchVal1_i  in  64  operand 1 (dividend) value, meaningful if dispatchVal1Ready_i.
dispatchVal1Ready_i  in  1  operand 1 already available.
dispatchVal1Tag_i  in  ROBsizeLog  producer ROB tag of operand 1 when not ready.
dispatchVal2_i  in  64  operand 2 (divisor) value.
dispatchVal2Ready_i  in  1  operand 2 already available.
dispatchVal2Tag_i  in  ROBsizeLog  producer ROB tag of operand 2.
dispatchCommands_i  in  10  control/command bits carried through.
dispatchTag_i  in  ROBsizeLog  ROB tag of this op.
full_o  out  1  no free entry; dispatch is ignored.
cdbValid_i  in  1  CDB broadcast valid.
cdbTag_i  in  ROBsizeLog  broadcast ROB tag.
cdbVal_i  in  64  broadcast value.
reservationStationVal1_o  out  64  selected op's dividend.
reservationStationVal2_o  out  64  selected op's divisor.
reservationStationCommands_o  out  10  selected op's commands.
reservationStationTag_o  out  ROBsizeLog  selected op's ROB tag.
readyRS_o  out  1  an op is presented.
stallRS_i  in  1  from divider stage; high means the presented op is not taken.

Behaviour:
- Entry state: valid, v1Rdy, v1, t1, v2Rdy, v2, t2, cmd, tag. Reset clears every valid bit. Outputs after reset: readyRS_o=0, full_o=0, data outputs=0.
- full_o = all entries valid. It is registered occupancy only; a same-cycle issue does not free space for a same-cycle dispatch.
- Dispatch: when dispatchValid_i and not full_o, write to the lowest-index free entry on the next edge.
- Same-cycle CDB capture on dispatch: if an operand is not ready, cdbValid_i is high and cdbTag_i equals that operand's tag, store cdbVal_i and set the ready bit.
- Wakeup: each edge, every valid entry with a not-ready operand whose tag matches cdbTag_i (cdbValid_i high) captures cdbVal_i and sets ready. Both operands may wake in the same cycle.
- Selection: an entry is ready when valid & v1Rdy & v2Rdy. Among ready entries, the one with the oldest age is selected; ties are impossible.
- Age tracking: a per-entry age counter (width $clog2(RSsize)) is set to 0 on dispatch. All other valid entries increment on dispatch.
- Outputs: readyRS_o = any ready entry. Data outputs are a combinational mux of the selected entry, and are 0 when none is selected.
- readyRS_o must not depend combinationally on stallRS_i.
- Transfer: occurs when readyRS_o & ~stallRS_i; the selected entry is cleared on that edge.
- While stalled, the presented op holds stable unless an older entry becomes ready. Selection is by age, so a newly woken entry never displaces an older presented one; a newly woken older entry may.
- Simultaneous dispatch + issue + CDB in one cycle are all honoured independently.
- flush_i: clears all valid bits next edge, overriding dispatch. Wakeup into cleared entries is discarded. The readyRS_o of the flush cycle still reflects current contents.
- reset_i mid-operation: immediate clear regardless of clock.

Optional Feature:
DIV_RS_BYPASS_EN
- Defined, and no stored entry ready: a dispatch with both operands ready (directly or via same-cycle CDB) is presented combinationally with readyRS_o=1. If ~stallRS_i it is consumed and not written; otherwise it is written normally (requires not full_o).
- Undefined: every op spends at least one cycle in an entry; minimum dispatch-to-readyRS_o latency is 1 cycle.

Test Plan:
- Reset, then dispatch Val1=15, Val2=3, both ready, cmd=10, tag=3, stallRS_i=0 -> next cycle readyRS_o=1 with 15/3/10/3; following cycle readyRS_o=0 (bypass off).
- Dispatch Val1 ready=20, Val2 waiting on tag 5; CDB tag 5 val 4 two cycles later -> readyRS_o rises the cycle after the CDB with Val2=4.
- Dispatch 4 ready ops tags 1,2,3,4 with stallRS_i=1 -> full_o=1; a 5th dispatch is ignored. Release the stall -> tags issue 1,2,3,4 on consecutive cycles and full_o drops after the first.
- Dispatch with operand tag 6 while CDB broadcasts tag 6 val 9 the same cycle -> entry stores 9, ready next cycle.
- Three ops waiting; flush_i pulse -> all cleared, readyRS_o=0, full_o=0; a subsequent dispatch is accepted normally.
- DIV_RS_BYPASS_EN defined: empty RS, dispatch 15/3 ready, stallRS_i=0 -> readyRS_o=1 the same cycle and the RS stays empty.
